// File: rtl/gpu_pixel_writer_if.sv
// Bus bundle between the pixel writer and its neighbours: the batch capture
// handshake from the shader core and the framebuffer write stream.
// master: the pixel writer itself. slave: the shader core / framebuffer side.
interface gpu_pixel_writer_if #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned CH_BITS   = 4,
    parameter int unsigned ADDR_BITS = 12
);
    logic [WIDTH*WORD_SIZE*3-1:0] frame_in;
    logic                         frame_valid;
    logic                         frame_ready;
    logic                         fb_valid;
    logic                         fb_ready;
    logic [ADDR_BITS-1:0]         fb_addr;
    logic [3*CH_BITS-1:0]         fb_data;
    logic                         frame_done;

    modport master (
        input  frame_in,
        input  frame_valid,
        output frame_ready,
        output fb_valid,
        input  fb_ready,
        output fb_addr,
        output fb_data,
        output frame_done
    );

    modport slave (
        output frame_in,
        output frame_valid,
        input  frame_ready,
        input  fb_valid,
        output fb_ready,
        input  fb_addr,
        input  fb_data,
        input  frame_done
    );
endinterface

// File: rtl/gpu_pixel_writer.sv
// Pixel writer: captures a WIDTH-lane batch of fp16 RGB values, converts each
// channel to saturated CH_BITS-bit unsigned fixed point and streams one pixel
// per accepted fb handshake to a wrapping framebuffer address.
// Optional build macro GPU_PIXEL_ROUND_EN: round-half-up instead of truncation.
// WORD_SIZE must be 16 (fp16); CH_BITS is assumed to be at most 10.
module gpu_pixel_writer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned CH_BITS   = 4,
    parameter int unsigned FB_PIXELS = 4096,
    parameter int unsigned ADDR_BITS = 12
) (
    input logic               clock,
    input logic               reset,
    gpu_pixel_writer_if.master bus
);
    localparam int unsigned LaneBits = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ChMax    = (1 << CH_BITS) - 1;
    localparam logic [ADDR_BITS-1:0] LastAddr = ADDR_BITS'(FB_PIXELS - 1);
    localparam logic [LaneBits-1:0]  LastLane = LaneBits'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StConv, StSend} state_e;

    // fp16 -> unsigned fixed point. The value v*2^CH_BITS is formed by shifting
    // {hidden,m} right; one extra fraction bit is kept so rounding is a +1.
    function automatic logic [CH_BITS-1:0] fp16_to_fixed(input logic [15:0] h);
        logic        s;
        logic [4:0]  e;
        logic [9:0]  m;
        logic [10:0] mant;
        logic [4:0]  eff_e;
        logic [11:0] t;
        logic [12:0] q;
        int          sh;
        s     = h[15];
        e     = h[14:10];
        m     = h[9:0];
        mant  = {(e != 5'd0), m};
        eff_e = (e == 5'd0) ? 5'd1 : e;
        if (e == 5'd31 && m != 10'd0) return '0;
        if (s) return '0;
        // +inf and every v >= 1.0 saturate
        if (e >= 5'd15) return '1;
        sh = 25 - int'(CH_BITS) - int'(eff_e);
        if (sh >= 12) t = '0;
        else          t = {mant, 1'b0} >> sh;
`ifdef GPU_PIXEL_ROUND_EN
        q = ({1'b0, t} + 13'd1) >> 1;
`else
        q = {1'b0, t} >> 1;
`endif
        if (q > 13'(ChMax)) return '1;
        return q[CH_BITS-1:0];
    endfunction

    state_e                           state_q;
    logic [WIDTH*WORD_SIZE*3-1:0]     frame_q;
    logic [WIDTH-1:0][3*CH_BITS-1:0]  conv_q;
    logic [WIDTH-1:0][3*CH_BITS-1:0]  conv_all;
    logic [LaneBits-1:0]              lane_q;
    logic [LaneBits-1:0]              lane_next;
    logic [ADDR_BITS-1:0]             addr_q;
    logic [3*CH_BITS-1:0]             fb_data_q;
    logic                             fb_valid_q;
    logic                             frame_ready_q;
    logic                             frame_done_q;

    // Parallel conversion of every channel of the captured batch.
    always_comb begin
        conv_all = '0;
        for (int g = 0; g < int'(WIDTH); g++) begin
            conv_all[g] = {fp16_to_fixed(frame_q[(3*g)*WORD_SIZE +: 16]),
                           fp16_to_fixed(frame_q[(3*g+1)*WORD_SIZE +: 16]),
                           fp16_to_fixed(frame_q[(3*g+2)*WORD_SIZE +: 16])};
        end
    end

    // Next lane index, only used while lane_q is not the last lane.
    always_comb begin
        lane_next = lane_q + 1'b1;
    end

    // Capture / convert / send FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            frame_q       <= '0;
            conv_q        <= '0;
            lane_q        <= '0;
            addr_q        <= '0;
            fb_data_q     <= '0;
            fb_valid_q    <= 1'b0;
            frame_ready_q <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.frame_valid && frame_ready_q) begin
                        frame_q       <= bus.frame_in;
                        frame_ready_q <= 1'b0;
                        state_q       <= StConv;
                    end
                end
                StConv: begin
                    // Lane 0 comes straight from the converter so it is
                    // presented in the same cycle conv_q fills.
                    conv_q     <= conv_all;
                    fb_data_q  <= conv_all[0];
                    fb_valid_q <= 1'b1;
                    lane_q     <= '0;
                    state_q    <= StSend;
                end
                StSend: begin
                    if (bus.fb_ready) begin
                        addr_q <= (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
                        if (addr_q == LastAddr) frame_done_q <= 1'b1;
                        if (lane_q == LastLane) begin
                            lane_q        <= '0;
                            fb_valid_q    <= 1'b0;
                            frame_ready_q <= 1'b1;
                            state_q       <= StIdle;
                        end else begin
                            lane_q    <= lane_next;
                            fb_data_q <= conv_q[lane_next];
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.frame_ready = frame_ready_q;
    assign bus.fb_valid    = fb_valid_q;
    assign bus.fb_addr     = addr_q;
    assign bus.fb_data     = fb_data_q;
    assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Directed bench for gpu_pixel_writer, built with a 32-pixel frame so that
// address wrap and frame_done are reachable within a few batches.
module tb_gpu_pixel_writer;
    localparam int unsigned WIDTH     = 16;
    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned CH_BITS   = 4;
    localparam int unsigned FB_PIXELS = 32;
    localparam int unsigned ADDR_BITS = 5;

`ifdef GPU_PIXEL_ROUND_EN
    localparam logic [11:0] Lane1Exp = 12'hF2C;
`else
    localparam logic [11:0] Lane1Exp = 12'hF1C;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    gpu_pixel_writer_if #(
        .WIDTH    (WIDTH),
        .WORD_SIZE(WORD_SIZE),
        .CH_BITS  (CH_BITS),
        .ADDR_BITS(ADDR_BITS)
    ) bus ();

    gpu_pixel_writer #(
        .WIDTH    (WIDTH),
        .WORD_SIZE(WORD_SIZE),
        .CH_BITS  (CH_BITS),
        .FB_PIXELS(FB_PIXELS),
        .ADDR_BITS(ADDR_BITS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
        for (int i = 0; i < int'(WIDTH); i++) begin
            bus.frame_in[48*i +: 16]      = r;
            bus.frame_in[48*i + 16 +: 16] = g;
            bus.frame_in[48*i + 32 +: 16] = b;
        end
    endtask

    task automatic set_lane(input int i, input logic [15:0] r, input logic [15:0] g,
                            input logic [15:0] b);
        bus.frame_in[48*i +: 16]      = r;
        bus.frame_in[48*i + 16 +: 16] = g;
        bus.frame_in[48*i + 32 +: 16] = b;
    endtask

    initial begin
        bus.frame_valid = 1'b0;
        bus.fb_ready    = 1'b1;
        bus.frame_in    = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_frame_ready", 32'(bus.frame_ready), 32'd1);
        chk("rst_fb_valid",    32'(bus.fb_valid),    32'd0);
        chk("rst_fb_addr",     32'(bus.fb_addr),     32'd0);
        chk("rst_fb_data",     32'(bus.fb_data),     32'd0);
        chk("rst_frame_done",  32'(bus.frame_done),  32'd0);

        // Batch 1: 1.0 / 0.5 / 0.0 on every lane -> 0xF80, addr 0..15
        set_all(16'h3C00, 16'h3800, 16'h0000);
        bus.frame_valid = 1'b1;
        tick();
        bus.frame_valid = 1'b0;
        chk("b1_conv_ready", 32'(bus.frame_ready), 32'd0);
        chk("b1_conv_valid", 32'(bus.fb_valid),    32'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("b1_valid", 32'(bus.fb_valid),    32'd1);
            chk("b1_addr",  32'(bus.fb_addr),     32'(i));
            chk("b1_data",  32'(bus.fb_data),     32'h0F80);
            chk("b1_ready", 32'(bus.frame_ready), 32'd0);
            chk("b1_done",  32'(bus.frame_done),  32'd0);
        end
        tick();
        chk("b1_end_valid", 32'(bus.fb_valid),    32'd0);
        chk("b1_end_ready", 32'(bus.frame_ready), 32'd1);
        chk("b1_end_done",  32'(bus.frame_done),  32'd0);

        // Batch 2: special values, addr 16..31 with wrap and frame_done
        set_all(16'h0000, 16'h0000, 16'h0000);
        set_lane(0, 16'hBC00, 16'h7C00, 16'h7E00);
        set_lane(1, 16'h4000, 16'h2E00, 16'h3A00);
        bus.frame_valid = 1'b1;
        tick();
        bus.frame_valid = 1'b0;
        tick();
        chk("b2_l0_addr", 32'(bus.fb_addr), 32'd16);
        chk("b2_l0_data", 32'(bus.fb_data), 32'h00F0);
        tick();
        chk("b2_l1_addr", 32'(bus.fb_addr), 32'd17);
        chk("b2_l1_data", 32'(bus.fb_data), 32'(Lane1Exp));
        for (int i = 2; i < 16; i++) begin
            tick();
            chk("b2_addr", 32'(bus.fb_addr),    32'(16 + i));
            chk("b2_data", 32'(bus.fb_data),    32'd0);
            chk("b2_done", 32'(bus.frame_done), 32'd0);
        end
        tick();
        chk("wrap_done",  32'(bus.frame_done), 32'd1);
        chk("wrap_addr",  32'(bus.fb_addr),    32'd0);
        chk("wrap_valid", 32'(bus.fb_valid),   32'd0);
        tick();
        chk("wrap_done_pulse", 32'(bus.frame_done), 32'd0);

        // Batch 3: alternating fb_ready, each pixel held until accepted
        set_all(16'h3800, 16'h3C00, 16'h3A00);
        bus.frame_valid = 1'b1;
        tick();
        bus.frame_valid = 1'b0;
        bus.fb_ready    = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("bp_valid", 32'(bus.fb_valid), 32'd1);
            chk("bp_addr",  32'(bus.fb_addr),  32'(i));
            chk("bp_data",  32'(bus.fb_data),  32'h08FC);
            bus.fb_ready = 1'b0;
            tick();
            chk("bp_hold_addr", 32'(bus.fb_addr),  32'(i));
            chk("bp_hold_data", 32'(bus.fb_data),  32'h08FC);
            chk("bp_hold_done", 32'(bus.frame_done), 32'd0);
            bus.fb_ready = 1'b1;
            tick();
        end
        chk("bp_end_valid", 32'(bus.fb_valid),   32'd0);
        chk("bp_end_done",  32'(bus.frame_done), 32'd0);
        chk("bp_end_addr",  32'(bus.fb_addr),    32'd16);

        // Reset after 5 accepted pixels discards the batch
        set_all(16'h3800, 16'h3800, 16'h3800);
        bus.frame_valid = 1'b1;
        tick();
        bus.frame_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("mid_addr", 32'(bus.fb_addr), 32'd21);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_valid", 32'(bus.fb_valid),    32'd0);
        chk("mrst_addr",  32'(bus.fb_addr),     32'd0);
        chk("mrst_data",  32'(bus.fb_data),     32'd0);
        chk("mrst_ready", 32'(bus.frame_ready), 32'd1);
        tick();
        chk("mrst_quiet", 32'(bus.fb_valid), 32'd0);

        // frame_valid held high: one capture per IDLE visit, 3-cycle gap
        bus.frame_valid = 1'b1;
        tick();
        set_all(16'h3C00, 16'h3C00, 16'h3C00);
        chk("hold_conv_ready", 32'(bus.frame_ready), 32'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("hold_addr",  32'(bus.fb_addr),     32'(i));
            chk("hold_data",  32'(bus.fb_data),     32'h0888);
            chk("hold_ready", 32'(bus.frame_ready), 32'd0);
        end
        tick();
        chk("gap1_valid", 32'(bus.fb_valid),    32'd0);
        chk("gap1_ready", 32'(bus.frame_ready), 32'd1);
        tick();
        chk("gap2_valid", 32'(bus.fb_valid),    32'd0);
        chk("gap2_ready", 32'(bus.frame_ready), 32'd0);
        tick();
        chk("next_valid", 32'(bus.fb_valid), 32'd1);
        chk("next_addr",  32'(bus.fb_addr),  32'd16);
        chk("next_data",  32'(bus.fb_data),  32'h0FFF);
        bus.frame_valid = 1'b0;
        tick();
        chk("next_accept", 32'(bus.fb_addr), 32'd17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
